fetch_sequencer: RTL and testbench

- Multi-cycle fetch/decode control FSM that drives the instruction unit's control inputs: pc_ld, pc_inc, im_cs, im_rd, ir_ld and pc_sel.
- Consumes the instruction register word (IR_out).
- Resolves control flow itself: j, beq/bne, jr.
- Issues all other instructions to the execute stage over a valid/ready handshake.
- Sits between the instruction unit (upstream) and the execute/datapath control (downstream).

---
 rtl/fetch_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/decode control FSM.
// It drives the instruction unit's PC/IM/IR strobes and resolves j, beq/bne and jr locally.
// Every other instruction is handed to the execute stage over a valid/ready handshake.
// Control strobes are decoded from the state register. The one exception is the jr load,
// which happens in the same cycle that rs_valid reports the target on PC_in.
module fetch_sequencer #(
  parameter int         CNT_W      = 16,
  parameter logic [5:0] HALT_FUNCT = 6'h0D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      ir_in,
  input  logic             ex_ready,
  input  logic             cond_valid,
  input  logic             cond_eq,
  input  logic             rs_valid,
  output logic             pc_ld,
  output logic             pc_inc,
  output logic             im_cs,
  output logic             im_rd,
  output logic             ir_ld,
  output logic [1:0]       pc_sel,
  output logic             issue_valid,
  output logic [31:0]      issue_instr,
  output logic             cmp_req,
  output logic             jr_req,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_JUMP    = 4'd3,
    S_BR_WAIT = 4'd4,
    S_BR_TAKE = 4'd5,
    S_JR_WAIT = 4'd6,
    S_ISSUE   = 4'd7,
    S_CHECK   = 4'd8,
    S_HALT    = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] SEL_PC_IN  = 2'b00;
  localparam logic [1:0] SEL_JUMP   = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  pc_sel_nxt;
  logic [31:0] issue_instr_nxt;
  logic        br_ne;        // captured branch sense: 1 for bne, 0 for beq
  logic        br_ne_nxt;
  logic        retire;       // one instruction completes on this edge
  logic [5:0]  opcode;
  logic [5:0]  funct;

  assign opcode = ir_in[31:26];
  assign funct  = ir_in[5:0];

  // Next-state selection, retire strobe and fields captured while decoding
  always_comb begin
    state_nxt       = state;
    retire          = 1'b0;
    pc_sel_nxt      = pc_sel;
    issue_instr_nxt = issue_instr;
    br_ne_nxt       = br_ne;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
        else     state_nxt = S_IDLE;
      end
      S_FETCH: begin
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OP_J) begin
          pc_sel_nxt = SEL_JUMP;
          state_nxt  = S_JUMP;
        end else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
          pc_sel_nxt = SEL_BRANCH;
          br_ne_nxt  = (opcode == OP_BNE);
          state_nxt  = S_BR_WAIT;
        end else if ((opcode == OP_RTYPE) && (funct == FN_JR)) begin
          pc_sel_nxt = SEL_PC_IN;
          state_nxt  = S_JR_WAIT;
        end else if ((opcode == OP_RTYPE) && (funct == HALT_FUNCT)) begin
          state_nxt = S_HALT;
        end else begin
          // Unknown opcodes land here too; the execute stage owns illegal-op handling.
          issue_instr_nxt = ir_in;
          state_nxt       = S_ISSUE;
        end
      end
      S_JUMP: begin
        retire    = 1'b1;
        state_nxt = S_CHECK;
      end
      S_BR_WAIT: begin
        if (cond_valid) begin
          retire = 1'b1;
          if (cond_eq ^ br_ne) state_nxt = S_BR_TAKE;
          else                 state_nxt = S_CHECK;
        end else begin
          state_nxt = S_BR_WAIT;
        end
      end
      S_BR_TAKE: begin
        state_nxt = S_CHECK;
      end
      S_JR_WAIT: begin
        if (rs_valid) begin
          retire    = 1'b1;
          state_nxt = S_CHECK;
        end else begin
          state_nxt = S_JR_WAIT;
        end
      end
      S_ISSUE: begin
        if (ex_ready) begin
          retire    = 1'b1;
          state_nxt = S_CHECK;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_CHECK: begin
        if (run) state_nxt = S_FETCH;
        else     state_nxt = S_IDLE;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Control strobes decoded from state; fetch strobes never overlap a PC load
  always_comb begin
    pc_ld       = 1'b0;
    pc_inc      = 1'b0;
    im_cs       = 1'b0;
    im_rd       = 1'b0;
    ir_ld       = 1'b0;
    issue_valid = 1'b0;
    cmp_req     = 1'b0;
    jr_req      = 1'b0;
    halted      = 1'b0;
    case (state)
      S_FETCH: begin
        im_cs  = 1'b1;
        im_rd  = 1'b1;
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
      end
      S_JUMP:    pc_ld       = 1'b1;
      S_BR_TAKE: pc_ld       = 1'b1;
      S_BR_WAIT: cmp_req     = 1'b1;
      S_ISSUE:   issue_valid = 1'b1;
      S_HALT:    halted      = 1'b1;
      S_JR_WAIT: begin
        jr_req = 1'b1;
        pc_ld  = rs_valid;
      end
      default: begin
        pc_ld = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Decode-captured fields: PC source select, branch sense and the issued word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_sel      <= 2'b00;
      br_ne       <= 1'b0;
      issue_instr <= 32'h0000_0000;
    end else begin
      pc_sel      <= pc_sel_nxt;
      br_ne       <= br_ne_nxt;
      issue_instr <= issue_instr_nxt;
    end
  end

  // Retired-instruction counter, wraps modulo 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
    else             retired <= retired;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer.
// The driver classifies each instruction with a behavioural model and predicts three things:
// the visible events, the loop length and the retired count.
// A negedge monitor pops the predicted events and compares them against what the DUT presents.
module tb_fetch_sequencer;

  localparam int         CNT_W = 16;
  localparam logic [5:0] HALT  = 6'h0D;
  localparam logic [1:0] EV_ISSUE = 2'd0;
  localparam logic [1:0] EV_PCLD  = 2'd1;

  logic clk = 1'b0;
  logic reset, run, ex_ready, cond_valid, cond_eq, rs_valid;
  logic [31:0] ir_in;
  logic pc_ld, pc_inc, im_cs, im_rd, ir_ld, issue_valid, cmp_req, jr_req, halted;
  logic [1:0] pc_sel;
  logic [31:0] issue_instr;
  logic [CNT_W-1:0] retired;

  fetch_sequencer #(.CNT_W(CNT_W), .HALT_FUNCT(HALT)) dut (
    .clk(clk), .reset(reset), .run(run), .ir_in(ir_in), .ex_ready(ex_ready),
    .cond_valid(cond_valid), .cond_eq(cond_eq), .rs_valid(rs_valid),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .im_cs(im_cs), .im_rd(im_rd), .ir_ld(ir_ld),
    .pc_sel(pc_sel), .issue_valid(issue_valid), .issue_instr(issue_instr),
    .cmp_req(cmp_req), .jr_req(jr_req), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
  } ev_t;

  ev_t expq[$];
  int  errors = 0;
  int  checks = 0;

  // driver / model state
  int  cyc = 0;
  int  wcnt = 0;
  int  d_cur = 1;
  bit  ceq_cur = 1'b0;
  int  fetch_cyc = 0;
  int  exp_lat = 0;
  int  exp_wait = 0;
  bit  lat_valid = 1'b0;
  logic [CNT_W-1:0] model_ret = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // One clock; responders drive handshakes #1 after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cmp_req || jr_req || issue_valid) wcnt++;
    cond_valid = cmp_req ? (wcnt >= d_cur) : 1'($urandom);
    cond_eq    = (cmp_req && cond_valid) ? ceq_cur : 1'($urandom);
    rs_valid   = jr_req ? (wcnt >= d_cur) : 1'($urandom);
    ex_ready   = issue_valid ? (wcnt >= d_cur) : 1'($urandom);
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (ir_ld) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL fetch_timeout: no fetch strobe within 60 cycles, expected one");
    end
  endtask

  // Wait for FETCH, check the previous loop, then present instr and predict its behaviour
  task automatic run_instr(input logic [31:0] instr, input int d, input bit ceq);
    bit ok;
    bit halt_i;
    logic [5:0] op;
    logic [5:0] fn;
    bit taken;
    wait_fetch(ok);
    if (ok) begin
      if (lat_valid) begin
        check("loop_cycles", 64'(cyc - fetch_cyc), 64'(exp_lat));
        check("wait_cycles", 64'(wcnt), 64'(exp_wait));
      end
      check("retired", 64'(retired), 64'(model_ret));
    end
    fetch_cyc = cyc;
    wcnt      = 0;
    ir_in     = instr;
    d_cur     = d;
    ceq_cur   = ceq;
    op        = instr[31:26];
    fn        = instr[5:0];
    halt_i    = 1'b0;
    if (op == 6'h02) begin
      expq.push_back('{EV_PCLD, 32'd1});
      exp_lat  = 4;
      exp_wait = 0;
    end else if (op == 6'h04 || op == 6'h05) begin
      taken = (op == 6'h04) ? ceq : !ceq;
      if (taken) expq.push_back('{EV_PCLD, 32'd2});
      exp_lat  = 3 + d + (taken ? 1 : 0);
      exp_wait = d;
    end else if (op == 6'h00 && fn == 6'h08) begin
      expq.push_back('{EV_PCLD, 32'd0});
      exp_lat  = 3 + d;
      exp_wait = d;
    end else if (op == 6'h00 && fn == HALT) begin
      halt_i = 1'b1;
    end else begin
      expq.push_back('{EV_ISSUE, instr});
      exp_lat  = 3 + d;
      exp_wait = d;
    end
    if (!halt_i) model_ret = model_ret + 1'b1;
    lat_valid = ok && !halt_i;
  endtask

  function automatic logic [31:0] rand_alu();
    logic [31:0] r;
    r = $urandom;
    if (r[31:26] == 6'h02 || r[31:26] == 6'h04 || r[31:26] == 6'h05) r[31:26] = 6'h23;
    if (r[31:26] == 6'h00 && (r[5:0] == 6'h08 || r[5:0] == HALT)) r[5:0] = 6'h20;
    return r;
  endfunction

  // Monitor: pops predicted events, checks strobe invariants and issue stability
  initial begin
    ev_t ev;
    logic prev_iv, prev_hs;
    logic [31:0] prev_instr;
    prev_iv = 1'b0;
    prev_hs = 1'b0;
    prev_instr = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_iv = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (prev_iv && !prev_hs)
          check("issue_hold", {31'h0, issue_valid, issue_instr}, {31'h0, 1'b1, prev_instr});
        if (issue_valid && ex_ready) begin
          if (expq.size() == 0) begin
            errors++; checks++;
            $display("FAIL issue_unexpected: got transfer of %0h, expected none", issue_instr);
          end else begin
            ev = expq.pop_front();
            check("issue_kind", 64'(ev.kind), 64'(EV_ISSUE));
            check("issue_instr", 64'(issue_instr), 64'(ev.val));
          end
        end
        if (pc_ld) begin
          if (expq.size() == 0) begin
            errors++; checks++;
            $display("FAIL pcld_unexpected: got pc_ld with pc_sel %0d, expected none", pc_sel);
          end else begin
            ev = expq.pop_front();
            check("pcld_kind", 64'(ev.kind), 64'(EV_PCLD));
            check("pc_sel", 64'(pc_sel), 64'(ev.val[1:0]));
            check("pcld_no_inc", 64'(pc_inc), 64'd0);
          end
        end
        if (im_cs || im_rd || ir_ld || pc_inc)
          check("fetch_strobes", 64'({im_cs, im_rd, ir_ld, pc_inc, pc_ld}), 64'(5'b11110));
        if (halted)
          check("halt_quiet", 64'({pc_ld, pc_inc, im_cs, im_rd, ir_ld, issue_valid, cmp_req, jr_req}), 64'd0);
        prev_iv    = issue_valid;
        prev_hs    = issue_valid && ex_ready;
        prev_instr = issue_instr;
      end
    end
  end

  // Stimulus: directed cases, randomized mix, mid-issue reset, halt
  initial begin
    int nf;
    bit ok;
    int k;
    reset = 1'b0; run = 1'b0; ir_in = 32'h0; ex_ready = 1'b0;
    cond_valid = 1'b0; cond_eq = 1'b0; rs_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("reset_ctrl", 64'({pc_ld, pc_inc, im_cs, im_rd, ir_ld, pc_sel, issue_valid, cmp_req, jr_req, halted}), 64'd0);
    check("reset_instr", 64'(issue_instr), 64'd0);
    check("reset_retired", 64'(retired), 64'd0);
    step(); step();
    reset = 1'b0;
    step(); step();
    check("idle_quiet", 64'({pc_ld, pc_inc, im_cs, im_rd, ir_ld, issue_valid, cmp_req, jr_req, halted}), 64'd0);
    run = 1'b1;

    // straight-line, backpressure, jump, branches, jr
    repeat (3) run_instr(32'h012A4020, 1, 1'b0);
    run_instr(32'h012A4020, 6, 1'b0);
    run_instr(32'h08000010, 1, 1'b0);
    run_instr(32'h1109FFFF, 2, 1'b1);
    run_instr(32'h1109FFFF, 2, 1'b0);
    run_instr(32'h1509FFFF, 2, 1'b0);
    run_instr(32'h1509FFFF, 1, 1'b1);
    run_instr(32'h1109FFFF, 1, 1'b1);
    run_instr(32'h03E00008, 3, 1'b0);

    // run low: the current instruction completes, then no further fetch
    run_instr(32'h012A4020, 1, 1'b0);
    run = 1'b0;
    nf = 0;
    repeat (12) begin step(); if (ir_ld) nf++; end
    check("idle_nofetch", 64'(nf), 64'd0);
    check("idle_retired", 64'(retired), 64'(model_ret));
    run = 1'b1;
    lat_valid = 1'b0;

    // randomized mix
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        5:       run_instr({6'h02, 26'($urandom)}, 1, 1'b0);
        6:       run_instr({6'h04, 26'($urandom)}, $urandom_range(1, 4), 1'($urandom));
        7:       run_instr({6'h05, 26'($urandom)}, $urandom_range(1, 4), 1'($urandom));
        8:       run_instr({6'h00, 20'($urandom), 6'h08}, $urandom_range(1, 4), 1'b0);
        default: run_instr(rand_alu(), $urandom_range(1, 4), 1'b0);
      endcase
    end

    // reset while an issue is pending under backpressure
    run_instr(32'h012A4020, 40, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (issue_valid) begin ok = 1'b1; break; end
    end
    check("pre_reset_issue", 64'(ok), 64'd1);
    step(); step();
    reset = 1'b1;
    #1;
    expq.delete();
    model_ret = '0;
    lat_valid = 1'b0;
    check("rst_mid_ctrl", 64'({pc_ld, pc_inc, im_cs, im_rd, ir_ld, pc_sel, issue_valid, cmp_req, jr_req, halted}), 64'd0);
    check("rst_mid_instr", 64'(issue_instr), 64'd0);
    check("rst_mid_retired", 64'(retired), 64'd0);
    run = 1'b0;
    step();
    reset = 1'b0;
    nf = 0;
    repeat (4) begin step(); if (ir_ld || issue_valid) nf++; end
    check("post_reset_idle", 64'(nf), 64'd0);
    run = 1'b1;

    run_instr(32'h012A4020, 1, 1'b0);
    run_instr(32'h08000010, 1, 1'b0);

    // halt: no further strobes with run high, count unchanged
    run_instr(32'h0000000D, 1, 1'b0);
    nf = 0;
    repeat (20) begin step(); if (ir_ld || pc_ld) nf++; end
    check("halt_nofetch", 64'(nf), 64'd0);
    check("halted", 64'(halted), 64'd1);
    check("halt_retired", 64'(retired), 64'(model_ret));
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d events never seen, expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
